// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 config/ID stream stages.
package sha256_pkg;

  localparam int SIZE_W   = 64;
  localparam int SCHEME_W = 2;
  localparam int ID_W     = 6;
  localparam int CNT_W    = 32;

  // Fields carried on the config channel towards the message builder.
  typedef struct packed {
    logic [SIZE_W-1:0]   size;
    logic [SCHEME_W-1:0] scheme;
    logic                last;
  } sha256_cfg_t;

  // Split occupancy, encoded as {cfg_pend, id_pend}.
  typedef enum logic [1:0] {
    ST_EMPTY    = 2'b00,
    ST_ID_ONLY  = 2'b01,
    ST_CFG_ONLY = 2'b10,
    ST_BOTH     = 2'b11
  } split_state_e;

endpackage

// File: rtl/sha256_out_slot.sv
// Single-entry output register with a pending flag. A load captures the
// data and marks it pending; a valid/ready handshake clears the flag and
// leaves the data in place. A load wins over a handshake clear in the
// same cycle, which is what lets the split refill at full throughput.
module sha256_out_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         sync_rst,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         ready,
  output logic [W-1:0] data_out,
  output logic         pend,
  output logic         valid
);

  // Valid is hidden while the block is disabled; the flag itself is kept.
  assign valid = pend & en;

  // Pending flag and data register: reset, load, or drain on handshake.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_out <= '0;
      pend     <= 1'b0;
    end else if (sync_rst) begin
      data_out <= '0;
      pend     <= 1'b0;
    end else if (en) begin
      if (load) begin
        data_out <= data_in;
        pend     <= 1'b1;
      end else if (valid && ready) begin
        pend     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sha256_config_split.sv
// Forks a combined config+ID stream into a config stream (size, scheme,
// last) and an ID stream (id, last). An item is accepted only when both
// output slots are free or draining this cycle, so each consumer sees
// every item exactly once regardless of its drain rate.
// Optional build macro SHA256_CONFIG_SPLIT_CNT_EN adds a 32-bit
// split_count output counting items delivered on both channels.
module sha256_config_split #(
  parameter int SIZE_W   = sha256_pkg::SIZE_W,
  parameter int SCHEME_W = sha256_pkg::SCHEME_W,
  parameter int ID_W     = sha256_pkg::ID_W
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic                sync_rst,
  input  logic [SIZE_W-1:0]   cfg_in_size,
  input  logic [SCHEME_W-1:0] cfg_in_scheme,
  input  logic [ID_W-1:0]     cfg_in_id,
  input  logic                cfg_in_last,
  input  logic                cfg_in_valid,
  output logic                cfg_in_ready,
  output logic [SIZE_W-1:0]   cfg_out_size,
  output logic [SCHEME_W-1:0] cfg_out_scheme,
  output logic                cfg_out_last,
  output logic                cfg_out_valid,
  input  logic                cfg_out_ready,
  output logic [ID_W-1:0]     id_out,
  output logic                id_out_last,
  output logic                id_out_valid,
  input  logic                id_out_ready
`ifdef SHA256_CONFIG_SPLIT_CNT_EN
  ,
  output logic [sha256_pkg::CNT_W-1:0] split_count
`endif
);

  localparam int CFG_W = SIZE_W + SCHEME_W + 1;
  localparam int IDS_W = ID_W + 1;

  logic                    cfg_pend;
  logic                    id_pend;
  logic                    in_hs;
  logic                    slots_free;
  logic [CFG_W-1:0]        cfg_q;
  logic [IDS_W-1:0]        id_q;
  sha256_pkg::split_state_e state;

  assign state = sha256_pkg::split_state_e'({cfg_pend, id_pend});

  // Both slots can take a new item this cycle if each is empty or draining.
  // NOTE: give every always_comb output a default first so no path leaves
  // it unassigned and a latch is never inferred.
  always_comb begin
    slots_free = 1'b0;
    unique case (state)
      sha256_pkg::ST_EMPTY:    slots_free = 1'b1;
      sha256_pkg::ST_CFG_ONLY: slots_free = cfg_out_ready;
      sha256_pkg::ST_ID_ONLY:  slots_free = id_out_ready;
      sha256_pkg::ST_BOTH:     slots_free = cfg_out_ready & id_out_ready;
      default:                 slots_free = 1'b0;
    endcase
  end

  // Ready is withheld during either reset and while disabled.
  assign cfg_in_ready = nrst & en & ~sync_rst & slots_free;
  assign in_hs        = cfg_in_valid & cfg_in_ready;

  sha256_out_slot #(.W(CFG_W)) u_cfg_slot (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en),
    .sync_rst (sync_rst),
    .load     (in_hs),
    .data_in  ({cfg_in_size, cfg_in_scheme, cfg_in_last}),
    .ready    (cfg_out_ready),
    .data_out (cfg_q),
    .pend     (cfg_pend),
    .valid    (cfg_out_valid)
  );

  sha256_out_slot #(.W(IDS_W)) u_id_slot (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en),
    .sync_rst (sync_rst),
    .load     (in_hs),
    .data_in  ({cfg_in_id, cfg_in_last}),
    .ready    (id_out_ready),
    .data_out (id_q),
    .pend     (id_pend),
    .valid    (id_out_valid)
  );

  assign {cfg_out_size, cfg_out_scheme, cfg_out_last} = cfg_q;
  assign {id_out, id_out_last}                        = id_q;

`ifdef SHA256_CONFIG_SPLIT_CNT_EN
  logic cfg_hs;
  logic id_hs;
  logic item_done;

  // An item is complete when its last outstanding channel hands it off.
  assign cfg_hs    = cfg_out_valid & cfg_out_ready;
  assign id_hs     = id_out_valid & id_out_ready;
  assign item_done = (cfg_hs & (id_hs | ~id_pend)) | (id_hs & ~cfg_pend);

  // Delivered-item counter, wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      split_count <= '0;
    end else if (sync_rst) begin
      split_count <= '0;
    end else if (en && item_done) begin
      split_count <= split_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha256_config_split.sv
// Self-checking bench for sha256_config_split: directed table, a streaming
// burst, then randomized traffic against a queue-based reference model.
module tb_sha256_config_split;
  import sha256_pkg::*;

  logic          clk;
  logic          nrst;
  logic          en;
  logic          sync_rst;
  logic [63:0]   cfg_in_size;
  logic [1:0]    cfg_in_scheme;
  logic [5:0]    cfg_in_id;
  logic          cfg_in_last;
  logic          cfg_in_valid;
  logic          cfg_in_ready;
  logic [63:0]   cfg_out_size;
  logic [1:0]    cfg_out_scheme;
  logic          cfg_out_last;
  logic          cfg_out_valid;
  logic          cfg_out_ready;
  logic [5:0]    id_out;
  logic          id_out_last;
  logic          id_out_valid;
  logic          id_out_ready;
`ifdef SHA256_CONFIG_SPLIT_CNT_EN
  logic [31:0]   split_count;
`endif

  int tests;
  int fails;

  sha256_config_split dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .sync_rst       (sync_rst),
    .cfg_in_size    (cfg_in_size),
    .cfg_in_scheme  (cfg_in_scheme),
    .cfg_in_id      (cfg_in_id),
    .cfg_in_last    (cfg_in_last),
    .cfg_in_valid   (cfg_in_valid),
    .cfg_in_ready   (cfg_in_ready),
    .cfg_out_size   (cfg_out_size),
    .cfg_out_scheme (cfg_out_scheme),
    .cfg_out_last   (cfg_out_last),
    .cfg_out_valid  (cfg_out_valid),
    .cfg_out_ready  (cfg_out_ready),
    .id_out         (id_out),
    .id_out_last    (id_out_last),
    .id_out_valid   (id_out_valid),
    .id_out_ready   (id_out_ready)
`ifdef SHA256_CONFIG_SPLIT_CNT_EN
    ,
    .split_count    (split_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed vector: inputs applied for one cycle, outputs expected before the edge.
  typedef struct {
    logic        en, srst, vld, crdy, irdy;
    logic [63:0] size;
    logic [1:0]  sch;
    logic [5:0]  id;
    logic        last;
    logic        e_rdy, e_cv, e_iv;
    logic [63:0] e_size;
    logic [5:0]  e_id;
    logic        e_last;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic en_i, srst_i, vld_i, crdy_i, irdy_i,
                              input logic [63:0] size_i, input logic [1:0] sch_i,
                              input logic [5:0] id_i, input logic last_i,
                              input logic rdy_e, cv_e, iv_e,
                              input logic [63:0] size_e, input logic [5:0] id_e,
                              input logic last_e, input int cnt_e);
    vec_t v;
    v.en = en_i; v.srst = srst_i; v.vld = vld_i; v.crdy = crdy_i; v.irdy = irdy_i;
    v.size = size_i; v.sch = sch_i; v.id = id_i; v.last = last_i;
    v.e_rdy = rdy_e; v.e_cv = cv_e; v.e_iv = iv_e;
    v.e_size = size_e; v.e_id = id_e; v.e_last = last_e; v.e_cnt = cnt_e;
    return v;
  endfunction

  task automatic drive(input logic en_i, srst_i, vld_i, crdy_i, irdy_i,
                       input logic [63:0] size_i, input logic [1:0] sch_i,
                       input logic [5:0] id_i, input logic last_i);
    en = en_i; sync_rst = srst_i; cfg_in_valid = vld_i;
    cfg_out_ready = crdy_i; id_out_ready = irdy_i;
    cfg_in_size = size_i; cfg_in_scheme = sch_i; cfg_in_id = id_i; cfg_in_last = last_i;
  endtask

  // Reference model: one pending-item queue per consumer plus per-item delivery tally.
  typedef struct {
    logic [63:0] size;
    logic [1:0]  sch;
    logic [5:0]  id;
    logic        last;
    int          serial;
  } item_t;

  item_t       cq[$];
  item_t       iq[$];
  int          deliveries[int];
  logic [31:0] mcnt;
  int          next_serial;

  task automatic deliver(input int s);
    if (deliveries.exists(s)) deliveries[s]++;
    else deliveries[s] = 1;
    if (deliveries[s] == 2) mcnt++;
  endtask

  vec_t tbl[20];

  initial begin
    item_t it;
    logic  exp_rdy;
    logic  c_take, i_take;
    tests = 0;
    fails = 0;

    // Reset state check: even with en high and an offer, nothing moves.
    nrst = 1'b0;
    drive(1, 0, 1, 1, 1, 64'h1, 2'd1, 6'h1, 1);
    #1;
    check("rst_in_ready", cfg_in_ready, 0);
    check("rst_cfg_valid", cfg_out_valid, 0);
    check("rst_id_valid", id_out_valid, 0);
    check("rst_cfg_size", cfg_out_size, 0);
    check("rst_id", id_out, 0);
`ifdef SHA256_CONFIG_SPLIT_CNT_EN
    check("rst_count", split_count, 0);
`endif
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);

    // en srst vld crdy irdy size sch id last | rdy cv iv size id last cnt
    tbl[0]  = mk(1,0,1,1,1, 64'h200, 2'd0, 6'h05, 1,  1,0,0, 64'h0,   6'h00, 0, 0);
    tbl[1]  = mk(1,0,0,1,1, 64'h0,   2'd0, 6'h00, 0,  1,1,1, 64'h200, 6'h05, 1, 0);
    tbl[2]  = mk(1,0,0,1,1, 64'h0,   2'd0, 6'h00, 0,  1,0,0, 64'h200, 6'h05, 1, 1);
    tbl[3]  = mk(1,0,1,0,1, 64'h300, 2'd1, 6'h09, 0,  1,0,0, 64'h200, 6'h05, 1, 1);
    tbl[4]  = mk(1,0,1,0,1, 64'h400, 2'd2, 6'h0A, 1,  0,1,1, 64'h300, 6'h09, 0, 1);
    tbl[5]  = mk(1,0,1,0,1, 64'h400, 2'd2, 6'h0A, 1,  0,1,0, 64'h300, 6'h09, 0, 1);
    tbl[6]  = mk(1,0,1,0,1, 64'h400, 2'd2, 6'h0A, 1,  0,1,0, 64'h300, 6'h09, 0, 1);
    tbl[7]  = mk(1,0,1,0,1, 64'h400, 2'd2, 6'h0A, 1,  0,1,0, 64'h300, 6'h09, 0, 1);
    tbl[8]  = mk(1,0,1,1,1, 64'h400, 2'd2, 6'h0A, 1,  1,1,0, 64'h300, 6'h09, 0, 1);
    tbl[9]  = mk(1,0,0,0,0, 64'h0,   2'd0, 6'h00, 0,  0,1,1, 64'h400, 6'h0A, 1, 2);
    tbl[10] = mk(0,0,1,1,1, 64'h500, 2'd3, 6'h3F, 0,  0,0,0, 64'h400, 6'h0A, 1, 2);
    tbl[11] = mk(0,0,1,1,1, 64'h500, 2'd3, 6'h3F, 0,  0,0,0, 64'h400, 6'h0A, 1, 2);
    tbl[12] = mk(0,0,1,1,1, 64'h500, 2'd3, 6'h3F, 0,  0,0,0, 64'h400, 6'h0A, 1, 2);
    tbl[13] = mk(1,0,0,1,1, 64'h0,   2'd0, 6'h00, 0,  1,1,1, 64'h400, 6'h0A, 1, 2);
    tbl[14] = mk(1,0,0,1,1, 64'h0,   2'd0, 6'h00, 0,  1,0,0, 64'h400, 6'h0A, 1, 3);
    tbl[15] = mk(1,0,1,0,0, 64'hDEAD,2'd3, 6'h03, 1,  1,0,0, 64'h400, 6'h0A, 1, 3);
    tbl[16] = mk(1,0,0,0,1, 64'h0,   2'd0, 6'h00, 0,  0,1,1, 64'hDEAD,6'h03, 1, 3);
    tbl[17] = mk(1,1,0,0,0, 64'h0,   2'd0, 6'h00, 0,  0,1,0, 64'hDEAD,6'h03, 1, 3);
    tbl[18] = mk(1,0,0,1,1, 64'h0,   2'd0, 6'h00, 0,  1,0,0, 64'h0,   6'h00, 0, 0);
    tbl[19] = mk(1,0,0,1,1, 64'h0,   2'd0, 6'h00, 0,  1,0,0, 64'h0,   6'h00, 0, 0);

    for (int r = 0; r < 20; r++) begin
      @(negedge clk);
      drive(tbl[r].en, tbl[r].srst, tbl[r].vld, tbl[r].crdy, tbl[r].irdy,
            tbl[r].size, tbl[r].sch, tbl[r].id, tbl[r].last);
      #1;
      check($sformatf("tbl%0d_in_ready", r), cfg_in_ready, tbl[r].e_rdy);
      check($sformatf("tbl%0d_cfg_valid", r), cfg_out_valid, tbl[r].e_cv);
      check($sformatf("tbl%0d_id_valid", r), id_out_valid, tbl[r].e_iv);
      check($sformatf("tbl%0d_cfg_size", r), cfg_out_size, tbl[r].e_size);
      check($sformatf("tbl%0d_id", r), id_out, tbl[r].e_id);
      check($sformatf("tbl%0d_cfg_last", r), cfg_out_last, tbl[r].e_last);
      check($sformatf("tbl%0d_id_last", r), id_out_last, tbl[r].e_last);
`ifdef SHA256_CONFIG_SPLIT_CNT_EN
      check($sformatf("tbl%0d_count", r), split_count, tbl[r].e_cnt);
`endif
    end

    // Back-to-back streaming: ids 0..7 accepted and delivered on consecutive cycles.
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      drive(1, 0, k < 8, 1, 1, 64'h1000 + k, k[1:0], k[5:0], k == 7);
      #1;
      if (k < 9) check($sformatf("b2b%0d_in_ready", k), cfg_in_ready, 1);
      if (k >= 1 && k <= 8) begin
        check($sformatf("b2b%0d_cfg_valid", k), cfg_out_valid, 1);
        check($sformatf("b2b%0d_id_valid", k), id_out_valid, 1);
        check($sformatf("b2b%0d_id", k), id_out, k - 1);
        check($sformatf("b2b%0d_cfg_size", k), cfg_out_size, 64'h1000 + k - 1);
      end
      if (k == 9) begin
        check("b2b_end_cfg_valid", cfg_out_valid, 0);
        check("b2b_end_id_valid", id_out_valid, 0);
`ifdef SHA256_CONFIG_SPLIT_CNT_EN
        check("b2b_end_count", split_count, 8);
`endif
      end
    end

    // Randomized traffic against the queue model, starting from a fresh reset.
    @(negedge clk);
    nrst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nrst = 1'b1;
    mcnt = '0;
    next_serial = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      en            = ($urandom_range(0, 9) != 0);
      sync_rst      = en && ($urandom_range(0, 39) == 0);
      cfg_in_valid  = ($urandom_range(0, 3) != 0);
      cfg_out_ready = ($urandom_range(0, 2) != 0);
      id_out_ready  = ($urandom_range(0, 2) != 0);
      cfg_in_size   = {$urandom, $urandom};
      cfg_in_scheme = 2'($urandom);
      cfg_in_id     = 6'($urandom);
      cfg_in_last   = 1'($urandom);
      #1;
      exp_rdy = en && !sync_rst && (cq.size() == 0 || cfg_out_ready)
                               && (iq.size() == 0 || id_out_ready);
      check("rnd_in_ready", cfg_in_ready, exp_rdy);
      check("rnd_cfg_valid", cfg_out_valid, en && cq.size() != 0);
      check("rnd_id_valid", id_out_valid, en && iq.size() != 0);
      if (en && cq.size() != 0) begin
        check("rnd_cfg_size", cfg_out_size, cq[0].size);
        check("rnd_cfg_scheme", cfg_out_scheme, cq[0].sch);
        check("rnd_cfg_last", cfg_out_last, cq[0].last);
      end
      if (en && iq.size() != 0) begin
        check("rnd_id", id_out, iq[0].id);
        check("rnd_id_last", id_out_last, iq[0].last);
      end
`ifdef SHA256_CONFIG_SPLIT_CNT_EN
      check("rnd_count", split_count, mcnt);
`endif
      // Advance the model across the coming clock edge.
      if (sync_rst) begin
        cq.delete();
        iq.delete();
        mcnt = '0;
      end else if (en) begin
        c_take = (cq.size() != 0) && cfg_out_ready;
        i_take = (iq.size() != 0) && id_out_ready;
        if (c_take) begin it = cq.pop_front(); deliver(it.serial); end
        if (i_take) begin it = iq.pop_front(); deliver(it.serial); end
        if (cfg_in_valid && exp_rdy) begin
          it.size = cfg_in_size; it.sch = cfg_in_scheme; it.id = cfg_in_id;
          it.last = cfg_in_last; it.serial = next_serial;
          next_serial++;
          cq.push_back(it);
          iq.push_back(it);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
